// File: rtl/adder.sv
// adder: 32-bit two's-complement adder with combinational sum/flags and a registered debug side-channel
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset (side-channel only)
//   op1, op2                  32-bit operands
//   res, carry, overflow, zero combinational sum and flags
//   res_q, carry_q, overflow_q registered copies of res/carry/overflow
//   overflow_sticky           set by any sampled overflow, cleared only by rst
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        carry,
    output logic        overflow,
    output logic        zero,
    output logic [31:0] res_q,
    output logic        carry_q,
    output logic        overflow_q,
    output logic        overflow_sticky
);
    logic [32:0] sum;
    logic [31:0] res_d;
    logic        carry_d;
    logic        overflow_d;
    logic        overflow_sticky_d;
    assign sum      = {1'b0, op1} + {1'b0, op2};
    assign res      = sum[31:0];
    assign carry    = sum[32];
    // Signed overflow: operands share a sign that the result does not.
    assign overflow = (op1[31] == op2[31]) && (res[31] != op1[31]);
    assign zero     = (res == 32'h0);
    always_comb begin
        res_d             = res;
        carry_d           = carry;
        overflow_d        = overflow;
        overflow_sticky_d = overflow_sticky | overflow;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q           <= 32'h0;
            carry_q         <= 1'b0;
            overflow_q      <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            res_q           <= res_d;
            carry_q         <= carry_d;
            overflow_q      <= overflow_d;
            overflow_sticky <= overflow_sticky_d;
        end
    end
endmodule

// File: tb/tb_adder.sv
// tb_adder: self-checking bench for adder against an arithmetic reference model
module tb_adder;
    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] op1 = 32'h0;
    logic [31:0] op2 = 32'h0;
    logic [31:0] res, res_q;
    logic        carry, overflow, zero, carry_q, overflow_q, overflow_sticky;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_rq;
    logic        m_cq, m_vq, m_st;

    adder dut (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2),
        .res(res), .carry(carry), .overflow(overflow), .zero(zero),
        .res_q(res_q), .carry_q(carry_q), .overflow_q(overflow_q),
        .overflow_sticky(overflow_sticky)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v, output logic z);
        longint ua, ub, us, sa, sb, ss;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        us = ua + ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ss = sa + sb;
        r = us[31:0];
        c = us > 64'h0000_0000_FFFF_FFFF;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        z = (us % 64'h1_0000_0000) == 0;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v, z;
        op1 = a;
        op2 = b;
        #1;
        model(a, b, r, c, v, z);
        chk("res", res, r);
        chk("carry", {31'h0, carry}, {31'h0, c});
        chk("overflow", {31'h0, overflow}, {31'h0, v});
        chk("zero", {31'h0, zero}, {31'h0, z});
    endtask

    task automatic tick(input logic r_in);
        logic [31:0] r;
        logic c, v, z;
        rst = r_in;
        model(op1, op2, r, c, v, z);
        @(posedge clk);
        if (r_in) begin
            m_rq = 32'h0; m_cq = 1'b0; m_vq = 1'b0; m_st = 1'b0;
        end else begin
            m_rq = r; m_cq = c; m_vq = v; m_st = m_st | v;
        end
        #1;
        rst = 1'b0;
        chk("res_q", res_q, m_rq);
        chk("carry_q", {31'h0, carry_q}, {31'h0, m_cq});
        chk("overflow_q", {31'h0, overflow_q}, {31'h0, m_vq});
        chk("overflow_sticky", {31'h0, overflow_sticky}, {31'h0, m_st});
    endtask

    typedef struct {
        logic [31:0] a, b, r;
        logic        c, v, z;
    } vec_t;

    vec_t vecs[4] = '{
        '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
        '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
        '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1}
    };

    logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

    function automatic logic [31:0] pick();
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
    endfunction

    initial begin
        // Combinational path with the clock stopped, 10 ns per step.
        foreach (vecs[i]) begin
            op1 = vecs[i].a;
            op2 = vecs[i].b;
            #10;
            chk("nc_res", res, vecs[i].r);
            chk("nc_carry", {31'h0, carry}, {31'h0, vecs[i].c});
            chk("nc_overflow", {31'h0, overflow}, {31'h0, vecs[i].v});
            chk("nc_zero", {31'h0, zero}, {31'h0, vecs[i].z});
        end
        clk_en = 1'b1;
        tick(1'b1);
        chk("reset_res_q", res_q, 32'h0);
        chk("reset_sticky", {31'h0, overflow_sticky}, 32'h0);
        apply(32'h1, 32'h2);
        tick(1'b0);
        chk("plan_res_q", res_q, 32'h3);
        apply(32'hFFFF_FFFF, 32'h1);
        tick(1'b0);
        apply(32'h7FFF_FFFF, 32'h1);
        tick(1'b0);
        chk("plan_ovf_q", {31'h0, overflow_q}, 32'h1);
        chk("plan_sticky_set", {31'h0, overflow_sticky}, 32'h1);
        apply(32'h1, 32'h2);
        repeat (3) tick(1'b0);
        chk("plan_sticky_hold", {31'h0, overflow_sticky}, 32'h1);
        chk("plan_ovf_q_clr", {31'h0, overflow_q}, 32'h0);
        tick(1'b1);
        chk("plan_rst_res", res, 32'h3);
        chk("plan_rst_res_q", res_q, 32'h0);
        apply(32'h8000_0000, 32'h8000_0000);
        tick(1'b1);
        chk("plan_rst_wins", {31'h0, overflow_sticky}, 32'h0);
        chk("plan_rst_comb_ovf", {31'h0, overflow}, 32'h1);
        apply(32'h1, 32'h2);
        tick(1'b0);
        // Randomized operands with occasional reset.
        for (int n = 0; n < 200; n++) begin
            apply(pick(), pick());
            tick($urandom_range(0, 15) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
